fsm_share_ctrl: RTL and testbench

Sequencing controller and round-robin arbiter that shares one four-phase Idle/Start/Stop/Clear handshake FSM among up to four requesters. It drives the FSM's single control line `A` through the full Idle→Start→Stop→Clear→Idle cycle, using the FSM's `F` (Clear) and `G` (Idle) status outputs as acknowledgements. It grants exactly one requester per cycle and reports completion or timeout. It sits between requester logic and the shared FSM instance.

---
 rtl/fsm_share_pkg.sv | 26 ++
 rtl/fsm_share_ctrl_if.sv | 24 ++
 rtl/rr_pick.sv | 26 ++
 rtl/fsm_share_ctrl.sv | 140 ++++++++++++++
 tb/tb_fsm_share_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fsm_share_pkg.sv
// Shared types and constants for the shared-FSM sequencer and its arbiter.
package fsm_share_pkg;

    localparam int CW = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STOP  = 3'd2,
        ST_ARM   = 3'd3,
        ST_CLR   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ABORT = 3'd6
    } state_e;

    // Index of the set bit in a one-hot vector of up to four requesters.
    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fsm_share_ctrl_if.sv
// Requester / shared-FSM side bundle of the sequencer.
// master: the environment (requesters and the shared FSM); slave: the controller.
interface fsm_share_ctrl_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0] req;
    logic            f_in;
    logic            g_in;
    logic            a_out;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            error;
    logic            busy;

    modport master (
        output req, f_in, g_in,
        input  a_out, grant, done, error, busy
    );

    modport slave (
        input  req, f_in, g_in,
        output a_out, grant, done, error, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request after i_ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic            o_valid
);

    int w_idx;

    assign o_valid = |i_req;

    // Scan from farthest to nearest so the nearest request after the pointer wins.
    always_comb begin
        o_win = '0;
        w_idx = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (i_req[w_idx[PW-1:0]]) o_win = NREQ'(1) << w_idx;
        end
    end

endmodule

// File: rtl/fsm_share_ctrl.sv
// Sequencer that walks one shared Idle/Start/Stop/Clear FSM through a full
// cycle on behalf of a round-robin selected requester.
//
// state | meaning
// IDLE  | A low, waiting for a request while the shared FSM reports Idle
// RUN   | A high for HOLD cycles
// STOP  | A low for HOLD cycles
// ARM   | A high, waiting for the Clear flag (bounded by TMO)
// CLR   | A low, waiting for the Idle flag (bounded by TMO)
// DONE  | one-cycle completion pulse to the owner
// ABORT | one-cycle error pulse after a timeout
module fsm_share_ctrl
    import fsm_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int HOLD = 4,
    parameter int TMO  = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    fsm_share_ctrl_if.slave io_bus
);

    localparam int             PW        = $clog2(NREQ);
    localparam logic [CW-1:0]  C_HOLD_RL = CW'(HOLD - 1);
    localparam logic [CW-1:0]  C_TMO_RL  = CW'(TMO - 1);
    localparam logic [PW-1:0]  C_PTR_RST = PW'(NREQ - 1);

    state_e          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [PW-1:0]   r_ptr, w_ptr_nx;
    logic [NREQ-1:0] r_win, w_win_nx;
    logic [NREQ-1:0] w_pick;
    logic            w_valid;
    logic            w_cnt_zero;
    logic            w_own;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .i_req   (io_bus.req),
        .i_ptr   (r_ptr),
        .o_win   (w_pick),
        .o_valid (w_valid)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // State, counter, pointer and winner registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= C_PTR_RST;
            r_win   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ptr   <= w_ptr_nx;
            r_win   <= w_win_nx;
        end
    end

    // Next-state logic; the counter is reloaded on every state entry.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ptr_nx   = r_ptr;
        w_win_nx   = r_win;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid && io_bus.g_in) begin
                    w_state_nx = ST_RUN;
                    w_cnt_nx   = C_HOLD_RL;
                    w_win_nx   = w_pick;
                end
            end
            ST_RUN: begin
                if (w_cnt_zero) begin
                    w_state_nx = ST_STOP;
                    w_cnt_nx   = C_HOLD_RL;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            ST_STOP: begin
                if (w_cnt_zero) begin
                    w_state_nx = ST_ARM;
                    w_cnt_nx   = C_TMO_RL;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            // The acknowledge wins over the timeout on the last counted cycle.
            ST_ARM: begin
                if (io_bus.f_in) begin
                    w_state_nx = ST_CLR;
                    w_cnt_nx   = C_TMO_RL;
                end else if (w_cnt_zero) begin
                    w_state_nx = ST_ABORT;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            ST_CLR: begin
                if (io_bus.g_in) begin
                    w_state_nx = ST_DONE;
                    w_cnt_nx   = '0;
                end else if (w_cnt_zero) begin
                    w_state_nx = ST_ABORT;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            // The winner takes the lowest priority next round, aborted or not.
            ST_DONE, ST_ABORT: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
                w_ptr_nx   = PW'(oh2idx(4'(r_win)));
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign w_own = (r_state == ST_RUN) || (r_state == ST_STOP) ||
                   (r_state == ST_ARM) || (r_state == ST_CLR);

    assign io_bus.a_out = (r_state == ST_RUN) || (r_state == ST_ARM);
    assign io_bus.grant = w_own ? r_win : '0;
    assign io_bus.done  = (r_state == ST_DONE) ? r_win : '0;
    assign io_bus.error = (r_state == ST_ABORT);
    assign io_bus.busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fsm_share_ctrl.sv
// Directed bench for fsm_share_ctrl with a behavioural shared FSM model.
module tb_fsm_share_ctrl;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       f_block = 1'b0;
    logic       g_block = 1'b0;
    logic [1:0] m_ph;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [11:0] apat = 12'b1111_0000_1100;
    logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clk = ~clk;

    fsm_share_ctrl_if #(.NREQ(4)) u_if ();

    fsm_share_ctrl #(
        .NREQ (4),
        .HOLD (4),
        .TMO  (16)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (u_if)
    );

    // Shared FSM: 0 Idle, 1 Start, 2 Stop, 3 Clear; registered, advanced by A.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_ph <= 2'd0;
        else begin
            case (m_ph)
                2'd0: if (u_if.a_out)  m_ph <= 2'd1;
                2'd1: if (!u_if.a_out) m_ph <= 2'd2;
                2'd2: if (u_if.a_out)  m_ph <= 2'd3;
                default: if (!u_if.a_out) m_ph <= 2'd0;
            endcase
        end
    end

    assign u_if.f_in = (m_ph == 2'd3) && !f_block;
    assign u_if.g_in = (m_ph == 2'd0) && !g_block;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.req = '0;
        rst_n    = 1'b0;
        repeat (2) tick();
        chk("rst_a",     32'(u_if.a_out), 32'd0);
        chk("rst_grant", 32'(u_if.grant), 32'd0);
        chk("rst_done",  32'(u_if.done),  32'd0);
        chk("rst_error", 32'(u_if.error), 32'd0);
        chk("rst_busy",  32'(u_if.busy),  32'd0);
        rst_n = 1'b1;
        tick();

        // Single request: grant 12 cycles, A pattern, done in cycle 13.
        u_if.req = 4'b0001;
        tick();
        u_if.req = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            chk("single_grant", 32'(u_if.grant), 32'h1);
            chk("single_a",     32'(u_if.a_out), 32'(apat[11-i]));
            tick();
        end
        chk("single_done",  32'(u_if.done),  32'h1);
        chk("single_grant_off", 32'(u_if.grant), 32'h0);
        chk("single_busy_done", 32'(u_if.busy), 32'h1);
        tick();
        chk("single_busy_idle", 32'(u_if.busy), 32'h0);
        chk("single_done_off",  32'(u_if.done), 32'h0);

        // Fairness with all requesters asserted after reset.
        do_reset();
        u_if.req = 4'b1111;
        tick();
        for (int t = 0; t < 5; t++) begin
            chk("rr_grant", 32'(u_if.grant), 32'(exp_g[t]));
            repeat (12) tick();
            chk("rr_done", 32'(u_if.done), 32'(exp_g[t]));
            if (t == 4) u_if.req = 4'b0000;
            tick();
            chk("rr_idle_busy",  32'(u_if.busy),  32'h0);
            chk("rr_idle_grant", 32'(u_if.grant), 32'h0);
            if (t < 4) tick();
        end

        // Timeout in ARM: requester 1, clear flag withheld.
        u_if.req = 4'b0010;
        f_block  = 1'b1;
        tick();
        chk("tmo_grant", 32'(u_if.grant), 32'h2);
        repeat (8) tick();
        chk("tmo_arm_a", 32'(u_if.a_out), 32'h1);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("tmo_arm_hold",  32'(u_if.a_out), 32'h1);
            chk("tmo_arm_noerr", 32'(u_if.error), 32'h0);
        end
        tick();
        chk("tmo_error",       32'(u_if.error), 32'h1);
        chk("tmo_no_done",     32'(u_if.done),  32'h0);
        chk("tmo_grant_off",   32'(u_if.grant), 32'h0);
        u_if.req = 4'b1111;
        tick();
        chk("tmo_error_pulse", 32'(u_if.error), 32'h0);
        chk("tmo_idle_busy",   32'(u_if.busy),  32'h0);
        tick();
        chk("tmo_next_grant",  32'(u_if.grant), 32'h4);
        u_if.req = 4'b0000;

        // Late acknowledge: clear flag appears on the last counted ARM cycle.
        repeat (8) tick();
        chk("late_arm_a", 32'(u_if.a_out), 32'h1);
        repeat (15) tick();
        chk("late_last_a",     32'(u_if.a_out), 32'h1);
        chk("late_last_grant", 32'(u_if.grant), 32'h4);
        f_block = 1'b0;
        tick();
        chk("late_clr_a",     32'(u_if.a_out), 32'h0);
        chk("late_clr_grant", 32'(u_if.grant), 32'h4);
        chk("late_no_error",  32'(u_if.error), 32'h0);
        tick();
        chk("late_clr2_grant", 32'(u_if.grant), 32'h4);
        tick();
        chk("late_done",     32'(u_if.done),  32'h4);
        chk("late_no_error2", 32'(u_if.error), 32'h0);
        tick();
        chk("late_idle", 32'(u_if.busy), 32'h0);

        // Shared FSM not idle: request must wait for the idle flag.
        g_block  = 1'b1;
        u_if.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nidle_grant", 32'(u_if.grant), 32'h0);
            chk("nidle_busy",  32'(u_if.busy),  32'h0);
        end
        g_block = 1'b0;
        tick();
        chk("nidle_go_grant", 32'(u_if.grant), 32'h4);
        u_if.req = 4'b0000;

        // Asynchronous reset in STOP.
        repeat (5) tick();
        chk("mid_stop_a",     32'(u_if.a_out), 32'h0);
        chk("mid_stop_busy",  32'(u_if.busy),  32'h1);
        chk("mid_stop_grant", 32'(u_if.grant), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(u_if.grant), 32'h0);
        chk("arst_busy",  32'(u_if.busy),  32'h0);
        chk("arst_a",     32'(u_if.a_out), 32'h0);
        tick();
        chk("arst_done",  32'(u_if.done),  32'h0);
        chk("arst_error", 32'(u_if.error), 32'h0);
        rst_n    = 1'b1;
        u_if.req = 4'b1111;
        tick();
        chk("arst_first_grant", 32'(u_if.grant), 32'h1);
        u_if.req = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
